// File: rtl/led_index_sequencer_if.sv
// Signal bundle between the index sequencer and whatever controls it.
// The controller (master) drives run/mode/load; the sequencer (slave) returns index, step and dir.
interface led_index_sequencer_if;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] index;
    logic       step;
    logic       dir;

    modport master (
        output enable,
        output mode,
        output load,
        output load_val,
        input  index,
        input  step,
        input  dir
    );

    modport slave (
        input  enable,
        input  mode,
        input  load,
        input  load_val,
        output index,
        output step,
        output dir
    );
endinterface

// File: rtl/led_index_sequencer.sv
// Prescaled 3-bit LED position generator with up-wrap, down-wrap, bounce and hold patterns.
// All outputs come straight from flops; load beats enable, reset beats everything.
module led_index_sequencer #(
    parameter int unsigned DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_index_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [15:0] LAST_CNT = 16'(DIV - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [2:0]  index_q, index_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic        tick;
    mode_e       mode;

    assign mode = mode_e'(bus.mode);
    assign tick = bus.enable && (pcnt_q == LAST_CNT);

    always_comb begin
        pcnt_d  = pcnt_q;
        index_d = index_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (bus.load) begin
            index_d = bus.load_val;
            pcnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            unique case (mode)
                MODE_UP: begin
                    index_d = index_q + 3'd1;
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end
                MODE_DOWN: begin
                    index_d = index_q - 3'd1;
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end
                MODE_BOUNCE: begin
                    step_d = 1'b1;
                    // Reversal happens on the end value itself, so each end is shown for one step only.
                    if (!dir_q) begin
                        if (index_q == 3'd7) begin
                            index_d = 3'd6;
                            dir_d   = 1'b1;
                        end else begin
                            index_d = index_q + 3'd1;
                        end
                    end else begin
                        if (index_q == 3'd0) begin
                            index_d = 3'd1;
                            dir_d   = 1'b0;
                        end else begin
                            index_d = index_q - 3'd1;
                        end
                    end
                end
                default: begin
                    step_d = 1'b0;
                end
            endcase
        end else if (bus.enable) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            index_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            index_q <= index_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign bus.index = index_q;
    assign bus.step  = step_q;
    assign bus.dir   = dir_q;

endmodule

// File: tb/tb_led_index_sequencer.sv
// Bench for led_index_sequencer: directed scenarios followed by random traffic,
// all checked each cycle against a reflection-based pattern model.
module tb_led_index_sequencer;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    led_index_sequencer_if bus ();

    led_index_sequencer #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: enabled cycles since last tick/load, position, direction, pulse.
    int m_elapsed = 0;
    int m_idx     = 0;
    int m_dir     = 0;
    int m_step    = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Bounce walks a 14-position ring; positions 0..7 map to index going up, 8..13 mirror back down.
    task automatic model_tick(input int md);
        int p;
        case (md)
            0: begin m_idx = (m_idx + 1) % 8; m_dir = 0; m_step = 1; end
            1: begin m_idx = (m_idx + 7) % 8; m_dir = 1; m_step = 1; end
            2: begin
                p = (m_dir == 0) ? m_idx : (14 - m_idx) % 14;
                p = (p + 1) % 14;
                m_idx  = (p <= 7) ? p : 14 - p;
                m_dir  = (p > 7 || p == 0) ? 1 : 0;
                m_step = 1;
            end
            default: m_step = 0;
        endcase
    endtask

    task automatic model_edge(input int r, input int en, input int md, input int ld, input int lv);
        if (r != 0) begin
            m_elapsed = 0; m_idx = 0; m_dir = 0; m_step = 0;
        end else if (ld != 0) begin
            m_elapsed = 0; m_idx = lv; m_step = 0;
        end else if (en != 0) begin
            m_elapsed++;
            if (m_elapsed == DIV) begin
                m_elapsed = 0;
                model_tick(md);
            end else begin
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic en, input logic [1:0] md,
                         input logic ld, input logic [2:0] lv);
        rst          = r;
        bus.enable   = en;
        bus.mode     = md;
        bus.load     = ld;
        bus.load_val = lv;
        @(posedge clk);
        model_edge(int'(r), int'(en), int'(md), int'(ld), int'(lv));
        #1;
        check("index", int'(bus.index), m_idx);
        check("step",  int'(bus.step),  m_step);
        check("dir",   int'(bus.dir),   m_dir);
    endtask

    task automatic run(input logic [1:0] md, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, md, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 3'd0);
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.mode     = 2'b00;
        bus.load     = 1'b0;
        bus.load_val = 3'd0;
        #1;

        do_reset();
        check("rst_index", int'(bus.index), 0);
        check("rst_step",  int'(bus.step),  0);
        check("rst_dir",   int'(bus.dir),   0);

        // Up-wrap through a full revolution; index 1 appears on the 4th edge.
        run(2'b00, 3);
        check("up_before_first", int'(bus.index), 0);
        run(2'b00, 1);
        check("up_first", int'(bus.index), 1);
        check("up_first_step", int'(bus.step), 1);
        run(2'b00, 32);

        // Down-wrap from reset: 0 -> 7 with dir=1.
        do_reset();
        run(2'b01, 4);
        check("down_first", int'(bus.index), 7);
        check("down_dir", int'(bus.dir), 1);
        run(2'b01, 32);

        // Bounce over more than one full round trip.
        do_reset();
        run(2'b10, 64);

        // Load mid-count at pcnt=2, then load while disabled.
        do_reset();
        run(2'b00, 2);
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 3'd5);
        check("load_idx", int'(bus.index), 5);
        run(2'b00, 3);
        check("load_hold", int'(bus.index), 5);
        run(2'b00, 1);
        check("load_next", int'(bus.index), 6);
        run(2'b00, 2);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 3'd3);
        check("load_dis", int'(bus.index), 3);

        // Enable gap with partial count of 1.
        do_reset();
        run(2'b00, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
        run(2'b00, 2);
        check("gap_wait", int'(bus.index), 0);
        run(2'b00, 1);
        check("gap_step", int'(bus.index), 1);
        run(2'b00, 6);

        // Reset beats load during bounce with dir=1, index=4.
        do_reset();
        run(2'b10, 40);
        check("pre_rst_idx", int'(bus.index), 4);
        check("pre_rst_dir", int'(bus.dir), 1);
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 3'd6);
        check("rstpri_idx", int'(bus.index), 0);

        // Hold: prescaler runs, nothing else moves.
        run(2'b00, 10);
        run(2'b11, 12);
        check("hold_idx", int'(bus.index), 2);

        // Random traffic.
        begin
            logic [1:0] md;
            md = 2'b00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
                cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 9) < 8),
                      md,
                      ($urandom_range(0, 29) == 0),
                      3'($urandom_range(0, 7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
